// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-style datapath (fetch, decode, execute, memory, writeback).
// Latency: all outputs are combinational from state, opcode_i, zero_i, mem_ack_i and the wait counter; CPI is 3..5 plus memory waits.
// Backpressure: memory states hold mem_req_o until mem_ack_i, or abandon to FETCH after TIMEOUT unacknowledged cycles.
// Optional feature: define MULTICYCLE_CTRL_JUMP_EN to add the JUMP state for opcode 0x02 (otherwise 0x02 is illegal).
module multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [3:0] state_o,
  output logic       illegal_o,
  output logic       timeout_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [3:0] TMO_CNT = 4'(TIMEOUT);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8
`ifdef MULTICYCLE_CTRL_JUMP_EN
    ,JUMP    = 4'd9
`endif
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
  logic       mem_state;
  logic       expired;

  // State and wait-counter registers; reset lands in FETCH with a clean counter even mid-access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Wait counter: counts unacknowledged cycles inside one memory access, zero everywhere else,
  // so every entry into a memory state (including a FETCH retry) starts from zero.
  always_comb begin
    mem_state    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    expired      = mem_state && (wait_cnt == TMO_CNT) && !mem_ack_i;
    wait_cnt_nxt = '0;
    if (mem_state && !mem_ack_i && !expired) begin
      wait_cnt_nxt = wait_cnt + 4'd1;
    end
  end

  // Next-state and control outputs; an ack in the expiry cycle wins over the timeout.
  always_comb begin
    state_nxt    = state;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    i_or_d_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    pc_src_o     = 2'b00;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    illegal_o    = 1'b0;
    timeout_o    = 1'b0;

    case (state)
      FETCH: begin
        mem_req_o   = !expired;
        alu_src_b_o = 2'b01;
        if (mem_ack_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_nxt  = DECODE;
        end else if (expired) begin
          // Abandoned fetch: PC is left alone so the same address is retried.
          timeout_o = 1'b1;
          state_nxt = FETCH;
        end
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE, OP_ADDI, OP_SLTI: state_nxt = EXEC;
          OP_LW, OP_SW:               state_nxt = MEM_ADDR;
          OP_BEQ, OP_BNE:             state_nxt = BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
          OP_J:                       state_nxt = JUMP;
`endif
          default: begin
            illegal_o = 1'b1;
            state_nxt = FETCH;
          end
        endcase
      end
      EXEC: begin
        alu_src_a_o = 1'b1;
        state_nxt   = ALU_WB;
        if (opcode_i == OP_RTYPE) begin
          alu_src_b_o = 2'b00;
          alu_op_o    = 3'b010;
        end else begin
          alu_src_b_o = 2'b10;
          alu_op_o    = (opcode_i == OP_SLTI) ? 3'b011 : 3'b000;
        end
      end
      ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (opcode_i == OP_RTYPE);
        state_nxt   = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_nxt   = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_req_o = !expired;
        i_or_d_o  = 1'b1;
        if (mem_ack_i) begin
          state_nxt = MEM_WB;
        end else if (expired) begin
          timeout_o = 1'b1;
          state_nxt = FETCH;
        end
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_nxt    = FETCH;
      end
      MEM_WR: begin
        mem_req_o = !expired;
        mem_we_o  = !expired;
        i_or_d_o  = 1'b1;
        if (mem_ack_i) begin
          state_nxt = FETCH;
        end else if (expired) begin
          timeout_o = 1'b1;
          state_nxt = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b001;
        pc_src_o    = 2'b01;
        pc_write_o  = (opcode_i == OP_BEQ) ? zero_i : !zero_i;
        state_nxt   = FETCH;
      end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
        state_nxt  = FETCH;
      end
`endif
      default: state_nxt = FETCH;
    endcase

    // Reset holds FETCH but must not issue requests, writes or events while asserted.
    if (!rst_i) begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
      timeout_o   = 1'b0;
    end
  end

  // Expose the raw state encoding for observation.
  always_comb begin
    state_o = state;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: instruction-level trace model with randomized opcodes, ack delays and zero flag.
// Each instruction is expanded into the list of cycles it must take, and the DUT outputs are compared every cycle.
module tb_multicycle_ctrl;
  localparam int TO = 15;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       ack = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write;
  logic [1:0] pc_src;
  logic       reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       illegal, timeout;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero), .mem_ack_i(ack),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .i_or_d_o(i_or_d), .ir_write_o(ir_write),
    .pc_write_o(pc_write), .reg_write_o(reg_write), .pc_src_o(pc_src), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .state_o(state), .illegal_o(illegal), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic req, we, iod, irw, pcw, rw;
    logic [1:0] pcs;
    logic rdst, m2r, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic ill, tmo;
  } out_t;

  typedef struct packed {
    logic [5:0] op;
    logic       ack;
    logic       zero;
    out_t       o;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  logic cur_vld = 1'b0;
  out_t seen[$];
  int   checks = 0;
  int   failures = 0;

  // ---------------- model: expand one instruction into its expected cycles ----------------
  function automatic out_t blank(input logic [3:0] st);
    out_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic add_cyc(input logic [5:0] op, input logic a, input logic z, input out_t o);
    cyc_t c;
    c.op = op; c.ack = a; c.zero = z; c.o = o;
    q.push_back(c);
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom % 10);
    if (r < 6) return int'($urandom % 3);
    if (r < 9) return int'($urandom % (TO + 1));
    return TO + 1 + int'($urandom % 2);
  endfunction

  // One memory access that is acked after w idle cycles, or abandoned after TO idle cycles.
  task automatic mem_access(input logic [5:0] op, input logic [3:0] st, input int w, output bit ok);
    out_t o, t;
    o = blank(st);
    o.req = 1'b1;
    o.iod = (st != 4'd0);
    o.we  = (st == 4'd5);
    if (st == 4'd0) o.asb = 2'b01;
    ok = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      if (k == w) begin
        t = o;
        if (st == 4'd0) begin t.irw = 1'b1; t.pcw = 1'b1; end
        add_cyc(op, 1'b1, 1'($urandom % 2), t);
        ok = 1'b1;
        return;
      end else if (k == TO) begin
        t = o; t.req = 1'b0; t.we = 1'b0; t.tmo = 1'b1;
        add_cyc(op, 1'b0, 1'($urandom % 2), t);
        return;
      end else begin
        add_cyc(op, 1'b0, 1'($urandom % 2), o);
      end
    end
  endtask

  task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    out_t o;
    bit   ok;
    bit   r_t, m_t, b_t, j_t;
    mem_access(op, 4'd0, fw, ok);
    while (!ok) mem_access(op, 4'd0, rand_wait(), ok);
    r_t = (op == 6'h00) || (op == 6'h08) || (op == 6'h0A);
    m_t = (op == 6'h23) || (op == 6'h2B);
    b_t = (op == 6'h04) || (op == 6'h05);
    j_t = JEN && (op == 6'h02);
    o = blank(4'd1);
    o.asb = 2'b11;
    o.ill = !(r_t || m_t || b_t || j_t);
    add_cyc(op, 1'b0, 1'($urandom % 2), o);
    if (r_t) begin
      o = blank(4'd6); o.asa = 1'b1;
      o.asb = (op == 6'h00) ? 2'b00 : 2'b10;
      o.aop = (op == 6'h00) ? 3'b010 : ((op == 6'h0A) ? 3'b011 : 3'b000);
      add_cyc(op, 1'b0, 1'($urandom % 2), o);
      o = blank(4'd7); o.rw = 1'b1; o.rdst = (op == 6'h00);
      add_cyc(op, 1'b0, 1'($urandom % 2), o);
    end
    if (m_t) begin
      o = blank(4'd2); o.asa = 1'b1; o.asb = 2'b10;
      add_cyc(op, 1'b0, 1'($urandom % 2), o);
      mem_access(op, (op == 6'h23) ? 4'd3 : 4'd5, mw, ok);
      if (ok && op == 6'h23) begin
        o = blank(4'd4); o.rw = 1'b1; o.m2r = 1'b1;
        add_cyc(op, 1'b0, 1'($urandom % 2), o);
      end
    end
    if (b_t) begin
      o = blank(4'd8); o.asa = 1'b1; o.aop = 3'b001; o.pcs = 2'b01;
      o.pcw = (op == 6'h04) ? z : !z;
      add_cyc(op, 1'b0, z, o);
    end
    if (j_t) begin
      o = blank(4'd9); o.pcw = 1'b1; o.pcs = 2'b10;
      add_cyc(op, 1'b0, 1'($urandom % 2), o);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    out_t obs;
    if (cur_vld) begin
      obs = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, pc_src,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, timeout};
      seen.push_back(obs);
      checks++;
      if (obs !== cur.o) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t op=%h ack=%0d actual=%h required=%h",
                 $time, cur.op, cur.ack, obs, cur.o);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic string seq_str(input logic [3:0] s[$]);
    string r;
    r = "";
    foreach (s[i]) r = {r, $sformatf("%0d ", s[i])};
    return r;
  endfunction

  task automatic chk_seq(input string name, input logic [3:0] act[$], input logic [3:0] req[$]);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%s required=%s", name, seq_str(act), seq_str(req));
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {state, mem_req, mem_we, ir_write, pc_write, reg_write, illegal, timeout}, 32'h0);
  endtask

  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      opcode = c.op; ack = c.ack; zero = c.zero;
      cur = c; cur_vld = 1'b1;
      @(posedge clk); #1;
    end
    cur_vld = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    ack = 1'b0;
    rst = 1'b1;
  endtask

  // Build one directed instruction, pin the model's state trace to a literal, then run and pin the DUT trace.
  task automatic directed(input string name, input logic [5:0] op, input int fw, input int mw,
                          input logic z, input logic [3:0] lit[$]);
    logic [3:0] mst[$];
    logic [3:0] dst[$];
    q.delete();
    add_instr(op, fw, mw, z);
    foreach (q[i]) mst.push_back(q[i].o.st);
    chk_seq({name, "_model_states"}, mst, lit);
    seen.delete();
    run_n(q.size());
    foreach (seen[i]) dst.push_back(seen[i].st);
    chk_seq({name, "_dut_states"}, dst, lit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] lit[$];
    logic [5:0] ops[9];
    int         n_rw, n_wr;
    ops = '{6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

    // Reset with ack high: nothing may be requested or written.
    rst = 1'b0; ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_reset("reset_quiet");
    end
    release_reset();
    #1;
    chk("first_fetch_req", {state, mem_req}, {4'd0, 1'b1});

    // add, zero wait
    lit = '{4'd0, 4'd1, 4'd6, 4'd7};
    directed("add", 6'h00, 0, 0, 1'b0, lit);
    n_rw = 0;
    foreach (seen[i]) if (seen[i].rw) n_rw++;
    chk("add_reg_write_pulses", n_rw, 1);
    chk("add_reg_dst", seen[3].rdst, 1);

    // lw with 3 wait cycles in MEM_RD
    lit = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    directed("lw", 6'h23, 0, 3, 1'b0, lit);
    n_wr = 0;
    foreach (seen[i]) if (seen[i].we) n_wr++;
    chk("lw_no_mem_we", n_wr, 0);
    chk("lw_mem_to_reg", seen[7].m2r, 1);

    // beq / bne with zero set
    lit = '{4'd0, 4'd1, 4'd8};
    directed("beq", 6'h04, 0, 0, 1'b1, lit);
    chk("beq_pc_write_src", {seen[2].pcw, seen[2].pcs}, 3'b101);
    directed("bne", 6'h05, 1, 0, 1'b1, '{4'd0, 4'd0, 4'd1, 4'd8});
    chk("bne_pc_write", seen[3].pcw, 0);

    // sw whose write is never acked
    lit = '{4'd0, 4'd1, 4'd2};
    for (int i = 0; i <= TO; i++) lit.push_back(4'd5);
    directed("sw_timeout", 6'h2B, 0, TO + 1, 1'b0, lit);
    chk("sw_timeout_pulse", {seen[TO + 3].tmo, seen[TO + 3].req, seen[TO + 2].tmo}, 3'b100);
    n_rw = 0;
    foreach (seen[i]) if (seen[i].rw) n_rw++;
    chk("sw_timeout_no_reg_write", n_rw, 0);
    #4;
    chk("after_timeout_fetch", state, 0);
    #6;

    // illegal opcode
    lit = '{4'd0, 4'd1};
    directed("illegal_3f", 6'h3F, 0, 0, 1'b0, lit);
    chk("illegal_pulse", {seen[0].ill, seen[1].ill}, 2'b01);

    // jump opcode, feature-dependent
    if (JEN) lit = '{4'd0, 4'd1, 4'd9};
    else lit = '{4'd0, 4'd1};
    directed("jump", 6'h02, 0, 0, 1'b0, lit);
    chk("jump_illegal_flag", seen[1].ill, !JEN);

    // asynchronous reset in the middle of a read
    q.delete();
    add_instr(6'h23, 0, 8, 1'b0);
    run_n(4);
    chk("rd_in_access", {state, mem_req}, {4'd3, 1'b1});
    #2 rst = 1'b0;
    #1;
    chk("async_reset_mid_read", {state, mem_req}, {4'd0, 1'b0});
    q.delete();
    @(negedge clk);
    chk_reset("reset_held");
    release_reset();

    // randomized instruction mix
    q.delete();
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      op = ($urandom % 8 == 0) ? 6'($urandom) : ops[$urandom % 9];
      add_instr(op, rand_wait(), rand_wait(), 1'($urandom % 2));
    end
    run_n(q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
